// File: rtl/wide_add_seq_if.sv
// Request/result bundle for the wide add/subtract sequencer.
// Latency is set by the sequencer, not this bundle; it only carries the signals.
// Both directions use valid/ready; nothing transfers unless valid and ready are both high.
interface wide_add_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    // Requester / result consumer side
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/wide_add_seq.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate lookahead.
// Purely combinational, zero cycles.
// No flow control; callers own the handshake.
module csa16_cla (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] y,
    output logic        cout
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;

    // Bit P/G, group P/G, lookahead group carries, then ripple inside each 4-bit group
    always_comb begin
        p = a ^ b;
        g = a & b;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int i = 0; i < 3; i++) begin
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            end
        end
        y    = p ^ c;
        cout = gc[4];
    end
endmodule

// Multi-precision add/subtract: one shared 16-bit adder, one word per cycle, LSW first.
// Result valid exactly WORDS cycles after accept; request period WORDS+2 with out_ready high.
// in_ready only in IDLE; result held stable in DONE until out_ready.
module wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    wide_add_seq_if.slave bus
);
    localparam int W     = 16 * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-17:0]   res_sh;
    logic [W-1:0]    res_nxt;
    logic            carry;
    logic [IDX_W-1:0] idx;
    logic [15:0]     add_y;
    logic            add_cout;
    logic            accept;
    logic            last;
    logic            ovf_w;

    // Adder sees registered operands only, never the input ports
    csa16_cla u_add (
        .a    (a_sh[15:0]),
        .b    (b_sh[15:0]),
        .cin  (carry),
        .y    (add_y),
        .cout (add_cout)
    );

    assign bus.in_ready  = (state == IDLE) & rst_n;
    assign bus.out_valid = (state == DONE);
    assign accept        = bus.in_valid & bus.in_ready;
    assign last          = (idx == IDX_W'(WORDS - 1));
    // New word enters at the top; on the last word this is the full result
    assign res_nxt       = {add_y, res_sh};
    // On the last word a_sh/b_sh[15] are the operand sign bits (B already inverted for sub)
    assign ovf_w         = (a_sh[15] == b_sh[15]) & (add_y[15] != a_sh[15]);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE -> RUN on accept, RUN -> DONE on last word, DONE -> IDLE on out_ready
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-word shifting, and result registration on the final word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh         <= '0;
            b_sh         <= '0;
            res_sh       <= '0;
            carry        <= 1'b0;
            idx          <= '0;
            bus.out_sum  <= '0;
            bus.out_cout <= 1'b0;
            bus.out_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= bus.in_a;
                        b_sh  <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        carry <= bus.in_sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    carry  <= add_cout;
                    a_sh   <= a_sh >> 16;
                    b_sh   <= b_sh >> 16;
                    res_sh <= res_nxt[W-1:16];
                    idx    <= idx + 1'b1;
                    if (last) begin
                        bus.out_sum  <= res_nxt;
                        bus.out_cout <= add_cout;
                        bus.out_ovf  <= ovf_w;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and randomized checks of wide_add_seq with WORDS=4.
// Checks latency, result words/flags, hold behaviour, reset abort and request period.
// Result side is held off or released explicitly per step.
module tb_wide_add_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   prev_acc = 0;

    wide_add_seq_if #(.WORDS(4)) bus ();

    wide_add_seq #(.WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic [63:0] be;
        logic [64:0] s;
        logic        ov;
        be = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, be} + 65'(sub);
        ov = (a[63] == be[63]) && (s[63] != a[63]);
        return {s[64], ov, s[63:0]};
    endfunction

    // Present a request and return #1 after the accepting edge
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub);
        int n;
        n = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", 66'(bus.in_ready), 66'(1));
        @(posedge clk); #1;
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
    endtask

    // Count edges until out_valid, then compare {cout, ovf, sum}
    task automatic wait_result(input string tag, input logic [65:0] exp);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 66'(n), 66'(4));
        chk(tag, {bus.out_cout, bus.out_ovf, bus.out_sum}, exp);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_rel_vld"}, 66'(bus.out_valid), 66'(0));
        chk({tag, "_rel_rdy"}, 66'(bus.in_ready), 66'(1));
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rb;
        logic        rs;
        logic        seen;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_in_ready", 66'(bus.in_ready), 66'(0));
        chk("rst_out_valid", 66'(bus.out_valid), 66'(0));
        chk("rst_result", {bus.out_cout, bus.out_ovf, bus.out_sum}, 66'(0));
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 66'(bus.in_ready), 66'(1));

        // 1: all-ones + 1 wraps to zero with carry out
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_result("add_wrap", {1'b1, 1'b0, 64'h0});
        release_result("add_wrap");

        // 2: signed overflow on add
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_result("add_ovf", {1'b0, 1'b1, 64'h8000_0000_0000_0000});
        release_result("add_ovf");

        // 3: subtract with borrow, then subtract with signed overflow
        send(64'h0, 64'h1, 1'b1);
        wait_result("sub_borrow", {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        release_result("sub_borrow");
        send(64'h8000_0000_0000_0000, 64'h1, 1'b1);
        wait_result("sub_ovf", {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF});

        // 4: hold result with a competing request on the input
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 64'(i) * 64'h1111_1111;
            bus.in_b     = 64'h1;
            bus.in_sub   = 1'b0;
            @(posedge clk); #1;
            chk("hold_vld", 66'(bus.out_valid), 66'(1));
            chk("hold_rdy", 66'(bus.in_ready), 66'(0));
            chk("hold_result", {bus.out_cout, bus.out_ovf, bus.out_sum},
                {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
        end
        bus.in_a      = 64'h10;
        bus.in_b      = 64'h20;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_vld", 66'(bus.out_valid), 66'(0));
        chk("hold_release_rdy", 66'(bus.in_ready), 66'(1));
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("pending_accepted", 66'(bus.in_ready), 66'(0));
        wait_result("pending_add", {1'b0, 1'b0, 64'h30});
        release_result("pending_add");

        // 5: reset while RUN at word index 2
        send(64'h1111, 64'h2222, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_rdy_low", 66'(bus.in_ready), 66'(0));
        chk("abort_vld", 66'(bus.out_valid), 66'(0));
        chk("abort_result", {bus.out_cout, bus.out_ovf, bus.out_sum}, 66'(0));
        rst_n = 1'b1;
        #1;
        chk("abort_idle", 66'(bus.in_ready), 66'(1));
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        chk("abort_no_partial", 66'(seen), 66'(0));
        send(64'h0001_0002_0003_0004, 64'h0004_0003_0002_0001, 1'b0);
        wait_result("post_abort_add", {1'b0, 1'b0, 64'h0005_0005_0005_0005});
        release_result("post_abort_add");

        // 6: random traffic with the consumer always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs);
            if (i > 0) chk("rand_period", 66'(acc_cyc - prev_acc), 66'(6));
            prev_acc = acc_cyc;
            wait_result("rand", model(ra, rb, rs));
        end
        bus.out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
